// File: rtl/adder_pkg.sv
// Shared constants for the adder family: default operand width and pipeline depth,
// plus the sign-based overflow rule used by every adder flavour.
package adder_pkg;

    localparam int ADDER_WIDTH  = 64;
    localparam int ADDER_STAGES = 4;

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One carry slice of the pipelined adder: W-bit operands plus carry-in,
// producing a W-bit sum and carry-out.
module adder_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] total_s;

    assign total_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    assign s       = total_s[W-1:0];
    assign co      = total_s[W];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract: slice k of the sum is formed in stage k and its carry is
// registered into stage k+1. A single global enable freezes the whole pipe on back-pressure.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH,
    parameter int STAGES = ADDER_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int MSB   = WIDTH - 1;
    localparam int LAST  = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("adder_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic             en;
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic             c_in [STAGES];
    logic             v_in [STAGES];

    logic [CHUNK-1:0] slice_sum [STAGES];
    logic             slice_co  [STAGES];

    // Operand registers carry the whole word so upper slices stay skewed until their
    // stage; completed lower sum bits ride along so all result bits leave together.
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_d [STAGES];
    logic             c_q [STAGES];
    logic             v_d [STAGES];
    logic             v_q [STAGES];
    logic             ovf_d;
    logic             ovf_q;

    assign en       = !v_q[LAST] || out_ready;
    assign in_ready = en;

    // Stage inputs: stage 0 takes the (possibly inverted) operands, later stages the previous registers
    always_comb begin
        a_in[0] = in1;
        b_in[0] = sub ? ~in2 : in2;
        s_in[0] = '0;
        c_in[0] = cin ^ sub;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .W (CHUNK)
        ) u_slice (
            .a  (a_in[k][k*CHUNK +: CHUNK]),
            .b  (b_in[k][k*CHUNK +: CHUNK]),
            .ci (c_in[k]),
            .s  (slice_sum[k]),
            .co (slice_co[k])
        );
    end

    // Next-state: insert each stage's slice result; overflow is resolved once the top slice is known
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]                    = a_in[k];
            b_d[k]                    = b_in[k];
            s_d[k]                    = s_in[k];
            s_d[k][k*CHUNK +: CHUNK]  = slice_sum[k];
            c_d[k]                    = slice_co[k];
            v_d[k]                    = v_in[k];
        end
        ovf_d = signed_ovf(a_in[LAST][MSB], b_in[LAST][MSB], s_d[LAST][MSB]);
    end

    // Pipeline registers: synchronous clear, otherwise advance only when the global enable is high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                v_q[k] <= v_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: builds with STAGES=4 (back-pressured), 1 and 8,
// all checked against an integer-arithmetic reference model.
module tb_adder_pipe;

    localparam int W = 64;
    localparam logic signed [W+2:0] SMAX = {4'b0000, {(W-1){1'b1}}};
    localparam logic signed [W+2:0] SMIN = ~SMAX;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
        int           stalls;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, cin, sub, out_ready;
    logic [W-1:0] in1, in2;
    logic         in_ready4, out_valid4, cout4, ovf4;
    logic         in_ready1, out_valid1, cout1, ovf1;
    logic         in_ready8, out_valid8, cout8, ovf8;
    logic [W-1:0] sum4, sum1, sum8;

    txn_t q4[$], q1[$], q8[$];
    txn_t e4, e1, e8;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   stalls = 0;
    bit   rand_ready = 1'b0;
    logic         hold_prev;
    logic [W-1:0] prev_sum;
    logic         prev_cout, prev_ovf;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(W), .STAGES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in1(in1), .in2(in2), .cin(cin), .sub(sub),
        .out_valid(out_valid4), .out_ready(out_ready),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    adder_pipe #(.WIDTH(W), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in1(in1), .in2(in2), .cin(cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(1'b1),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    adder_pipe #(.WIDTH(W), .STAGES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .in1(in1), .in2(in2), .cin(cin), .sub(sub),
        .out_valid(out_valid8), .out_ready(1'b1),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    // Add: a + b + c.  Subtract: a - b - c (c is a borrow); cout = 1 when no borrow.
    // Overflow: the exact signed result does not fit in W bits.
    function automatic txn_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
        logic signed [W+2:0] ua, ub, uc, ur, sa, sb, sr;
        txn_t t;
        ua = {3'b000, a};
        ub = {3'b000, b};
        uc = {{(W+2){1'b0}}, c};
        sa = {{3{a[W-1]}}, a};
        sb = {{3{b[W-1]}}, b};
        if (s) begin
            ur = ua - ub - uc;
            sr = sa - sb - uc;
        end else begin
            ur = ua + ub + uc;
            sr = sa + sb + uc;
        end
        t.sum    = ur[W-1:0];
        t.cout   = s ? !ur[W+2] : ur[W];
        t.ovf    = (sr > SMAX) || (sr < SMIN);
        t.cyc    = cyc;
        t.stalls = stalls;
        return t;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_txn(input string tag, input txn_t e, input logic [W-1:0] s,
                             input logic co, input logic ov, input int stages, input bit lat_ok);
        chk({tag, "_sum"}, s, e.sum);
        chk({tag, "_cout"}, W'(co), W'(e.cout));
        chk({tag, "_ovf"}, W'(ov), W'(e.ovf));
        if (lat_ok) chk({tag, "_latency"}, W'(cyc - e.cyc), W'(stages));
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!out_ready) stalls <= stalls + 1;
    end

    // Acceptance: record the expected response of every transaction a build takes
    always @(negedge clk) begin
        if (rst_n && in_valid) begin
            if (in_ready4) q4.push_back(ref_model(in1, in2, cin, sub));
            if (in_ready1) q1.push_back(ref_model(in1, in2, cin, sub));
            if (in_ready8) q8.push_back(ref_model(in1, in2, cin, sub));
        end
    end

    // Monitor for the back-pressured build: handshake rule, hold-while-stalled, results
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev <= 1'b0;
        end else begin
            chk("in_ready_rule", W'(in_ready4), W'(!out_valid4 || out_ready));
            if (hold_prev) begin
                chk("hold_valid", W'(out_valid4), W'(1'b1));
                chk("hold_sum", sum4, prev_sum);
                chk("hold_flags", W'({cout4, ovf4}), W'({prev_cout, prev_ovf}));
            end
            if (out_valid4 && out_ready) begin
                if (q4.size() == 0) begin
                    chk("spurious_s4", W'(out_valid4), W'(1'b0));
                end else begin
                    e4 = q4.pop_front();
                    check_txn("s4", e4, sum4, cout4, ovf4, 4, e4.stalls == stalls);
                end
            end
            hold_prev <= out_valid4 && !out_ready;
            prev_sum  <= sum4;
            prev_cout <= cout4;
            prev_ovf  <= ovf4;
        end
    end

    // Monitors for the always-ready single- and eight-stage builds
    always @(negedge clk) begin
        if (rst_n && out_valid1) begin
            if (q1.size() == 0) chk("spurious_s1", W'(out_valid1), W'(1'b0));
            else begin
                e1 = q1.pop_front();
                check_txn("s1", e1, sum1, cout1, ovf1, 1, 1'b1);
            end
        end
        if (rst_n && out_valid8) begin
            if (q8.size() == 0) chk("spurious_s8", W'(out_valid8), W'(1'b0));
            else begin
                e8 = q8.pop_front();
                check_txn("s8", e8, sum8, cout8, ovf8, 8, 1'b1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in1 = a;
        in2 = b;
        cin = c;
        sub = s;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready4) done = 1'b1;
            else tick();
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles");
        end
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(W-1){1'b1}}};
            3:       v = {1'b1, {(W-1){1'b0}}};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0;
        cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", W'(out_valid4), W'(1'b0));
        chk("rst_sum", sum4, '0);
        chk("rst_flags", W'({cout4, ovf4}), W'(2'b00));
        chk("rst_in_ready", W'(in_ready4), W'(1'b1));
        chk("rst_valid_1_8", W'({out_valid1, out_valid8}), W'(2'b00));
        tick();

        send({W{1'b1}}, '0, 1'b1, 1'b0);
        send(64'd5, 64'd7, 1'b0, 1'b1);
        send({1'b0, {(W-1){1'b1}}}, 64'd1, 1'b0, 1'b0);
        repeat (10) tick();

        // Eight back-to-back accepts with a three-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 8; i++) send({$urandom, $urandom}, {$urandom, $urandom},
                                                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (5) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        repeat (12) tick();

        // Three in flight, then a one-cycle reset
        for (int i = 0; i < 3; i++) send(pick_operand(), pick_operand(), 1'b0, 1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q4.delete();
        q1.delete();
        q8.delete();
        @(negedge clk);
        chk("post_rst_valid", W'(out_valid4), W'(1'b0));
        chk("post_rst_valid8", W'(out_valid8), W'(1'b0));
        chk("post_rst_sum", sum4, '0);
        tick();
        repeat (12) tick();

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            else send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (q4.size() + q1.size() + q8.size()) != 0; i++) tick();
        repeat (2) tick();
        chk("drain_s4", W'(q4.size()), '0);
        chk("drain_s1", W'(q1.size()), '0);
        chk("drain_s8", W'(q8.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
